// File: rtl/rv_pkg.sv
// Shared constants and types for the writeback port scheduler.
//   XLEN      - writeback data width
//   NREG      - number of architectural registers
//   reg_idx_t - register index type
//   wb_src_t  - writeback requester identity, also used as the grant bit index
package rv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned RegIdxW = $clog2(NREG);

  typedef logic [RegIdxW-1:0] reg_idx_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-input writeback arbiter with round-robin or fixed-priority resolution.
// Ports:
//   clock     - clock, state updates on posedge
//   reset     - synchronous active-high reset; last grant returns to the ALU
//   req[1:0]  - requests, bit SRC_ALU and bit SRC_LD
//   rr_enable - 1: round-robin on contention, 0: load unit always wins
//   gnt[1:0]  - one-hot grant, or zero when nothing is requested
module wb_rr_arb2
  import rv_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       rr_enable,
  output logic [1:0] gnt
);

  wb_src_t last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the ALU only wins when round-robin is on and the load unit went last.
      2'b11:   gnt = (rr_enable && (last_grant_q == SRC_LD)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[SRC_LD]) begin
      last_grant_d = SRC_LD;
    end else if (gnt[SRC_ALU]) begin
      last_grant_d = SRC_ALU;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Shares the single register-file write port between the ALU and the load unit, and
// keeps a per-register busy scoreboard for RAW/WAW stalls at issue.
// Ports:
//   clock, reset                      - clock and synchronous active-high reset
//   alu_valid/alu_rd/alu_data         - ALU writeback request; alu_ready accepts it
//   ld_valid/ld_rd/ld_data            - load writeback request; ld_ready accepts it
//   issue_valid/issue_rd, issue_ready - destination reservation at issue
//   rs1/rs2, rs1_busy/rs2_busy        - source busy queries
//   regWrite/writeRegId/writeData     - registered register-file write port
module wb_port_scheduler #(
  parameter int unsigned XLEN      = rv_pkg::XLEN,
  parameter int unsigned NREG      = rv_pkg::NREG,
  parameter bit          RR_ENABLE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  rv_pkg::reg_idx_t  alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  rv_pkg::reg_idx_t  ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  input  logic              issue_valid,
  input  rv_pkg::reg_idx_t  issue_rd,
  output logic              issue_ready,
  input  rv_pkg::reg_idx_t  rs1,
  input  rv_pkg::reg_idx_t  rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              regWrite,
  output rv_pkg::reg_idx_t  writeRegId,
  output logic [XLEN-1:0]   writeData
);

  import rv_pkg::*;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       alu_x0, ld_x0;
  logic       issue_fire;

  logic            reg_write_q, reg_write_d;
  reg_idx_t        write_reg_id_q, write_reg_id_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Writes to x0 are swallowed here so they never occupy the port.
  assign alu_x0 = (alu_rd == '0);
  assign ld_x0  = (ld_rd == '0);

  always_comb begin
    req          = 2'b00;
    req[SRC_ALU] = !reset && alu_valid && !alu_x0;
    req[SRC_LD]  = !reset && ld_valid && !ld_x0;
  end

  wb_rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .rr_enable (RR_ENABLE),
    .gnt       (gnt)
  );

  assign alu_ready = !reset && alu_valid && (alu_x0 || gnt[SRC_ALU]);
  assign ld_ready  = !reset && ld_valid && (ld_x0 || gnt[SRC_LD]);

  assign issue_ready = !reset && ((issue_rd == '0) || !busy_q[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

  // Index and data hold their last values when no write is granted.
  always_comb begin
    reg_write_d    = |gnt;
    write_reg_id_d = write_reg_id_q;
    write_data_d   = write_data_q;
    if (gnt[SRC_LD]) begin
      write_reg_id_d = ld_rd;
      write_data_d   = ld_data;
    end else if (gnt[SRC_ALU]) begin
      write_reg_id_d = alu_rd;
      write_data_d   = alu_data;
    end
  end

  // Clear lines up with the register-file commit; a same-index set is applied after
  // the clear so a fresh reservation is never lost.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_reg_id_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write_q    <= 1'b0;
      write_reg_id_q <= '0;
      write_data_q   <= '0;
      busy_q         <= '0;
    end else begin
      reg_write_q    <= reg_write_d;
      write_reg_id_q <= write_reg_id_d;
      write_data_q   <= write_data_d;
      busy_q         <= busy_d;
    end
  end

  assign regWrite   = reg_write_q;
  assign writeRegId = write_reg_id_q;
  assign writeData  = write_data_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: a round-robin instance carries the scoreboard checks,
// a fixed-priority instance shares the same stimulus for the priority scenario.
module tb_wb_port_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;

  logic        alu_ready, ld_ready, issue_ready, rs1_busy, rs2_busy, regWrite;
  logic [4:0]  writeRegId;
  logic [31:0] writeData;

  logic        fp_alu_ready, fp_ld_ready, fp_issue_ready, fp_rs1_busy, fp_rs2_busy;
  logic        fp_regWrite;
  logic [4:0]  fp_writeRegId;
  logic [31:0] fp_writeData;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  always #5 clock = ~clock;

  wb_port_scheduler #(.XLEN(32), .NREG(32), .RR_ENABLE(1'b1)) dut (
    .clock (clock), .reset (reset),
    .alu_valid (alu_valid), .alu_rd (alu_rd), .alu_data (alu_data), .alu_ready (alu_ready),
    .ld_valid (ld_valid), .ld_rd (ld_rd), .ld_data (ld_data), .ld_ready (ld_ready),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready),
    .rs1 (rs1), .rs2 (rs2), .rs1_busy (rs1_busy), .rs2_busy (rs2_busy),
    .regWrite (regWrite), .writeRegId (writeRegId), .writeData (writeData)
  );

  wb_port_scheduler #(.XLEN(32), .NREG(32), .RR_ENABLE(1'b0)) dut_fp (
    .clock (clock), .reset (reset),
    .alu_valid (alu_valid), .alu_rd (alu_rd), .alu_data (alu_data),
    .alu_ready (fp_alu_ready),
    .ld_valid (ld_valid), .ld_rd (ld_rd), .ld_data (ld_data), .ld_ready (fp_ld_ready),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (fp_issue_ready),
    .rs1 (rs1), .rs2 (rs2), .rs1_busy (fp_rs1_busy), .rs2_busy (fp_rs2_busy),
    .regWrite (fp_regWrite), .writeRegId (fp_writeRegId), .writeData (fp_writeData)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Each cycle: the write due now must appear, otherwise the port must be idle.
  always @(negedge clock) begin
    if (mon_en) begin
      n_vec++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (regWrite !== 1'b1 || writeRegId !== exp_q[0].rd || writeData !== exp_q[0].data) begin
          n_err++;
          $display("FAIL wb_write cyc=%0d: got we=%b rd=%0d data=%h, want we=1 rd=%0d data=%h",
                   cyc, regWrite, writeRegId, writeData, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else if (regWrite !== 1'b0) begin
        n_err++;
        $display("FAIL wb_idle cyc=%0d: got we=%b rd=%0d, want we=0", cyc, regWrite, writeRegId);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    ld_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.cyc  = cyc + 1;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h6;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1 = 5'd9; rs2 = 5'd0;
    next_cycle();
    @(negedge clock);
    n_vec += 3;
    if (alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
    if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clock);
    n_vec += 4;
    if (regWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %b want 0", regWrite); end
    if (writeRegId !== 5'd0) begin n_err++; $display("FAIL rst_regid: got %0d want 0", writeRegId); end
    if (writeData !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", writeData); end
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", rs1_busy); end
    next_cycle();
    mon_en = 1'b1;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd50;
    @(negedge clock);
    n_vec++;
    if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
    push_exp(5'd5, 32'd50);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'(i * 32'h101);
      @(negedge clock);
      n_vec++;
      if (alu_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, alu_ready);
      end
      push_exp(5'(i), 32'(i * 32'h101));
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_contention();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
    @(negedge clock);
    n_vec += 2;
    if (ld_ready !== 1'b1) begin n_err++; $display("FAIL cont_ld_first: got %b want 1", ld_ready); end
    if (alu_ready !== 1'b0) begin n_err++; $display("FAIL cont_alu_wait: got %b want 0", alu_ready); end
    push_exp(5'd4, 32'h44);
    next_cycle();
    ld_valid = 1'b0;
    @(negedge clock);
    n_vec++;
    if (alu_ready !== 1'b1) begin n_err++; $display("FAIL cont_alu_second: got %b want 1", alu_ready); end
    push_exp(5'd3, 32'h33);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_fixed_prio();
    mon_en = 1'b0;
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_vec += 3;
      if (fp_alu_ready !== 1'b0) begin
        n_err++; $display("FAIL fp_alu_stall[%0d]: got %b want 0", i, fp_alu_ready);
      end
      if (fp_ld_ready !== 1'b1) begin
        n_err++; $display("FAIL fp_ld_grant[%0d]: got %b want 1", i, fp_ld_ready);
      end
      if (alu_ready !== (i % 2 == 1)) begin
        n_err++; $display("FAIL rr_alternate[%0d]: got %b want %b", i, alu_ready, (i % 2 == 1));
      end
      if (i > 0) begin
        n_vec++;
        if (fp_regWrite !== 1'b1 || fp_writeRegId !== 5'd4) begin
          n_err++;
          $display("FAIL fp_write[%0d]: got we=%b rd=%0d want we=1 rd=4", i, fp_regWrite, fp_writeRegId);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    do_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_x0_bypass();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    @(negedge clock);
    n_vec += 2;
    if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
    if (ld_ready !== 1'b1) begin n_err++; $display("FAIL x0_ld_ready: got %b want 1", ld_ready); end
    push_exp(5'd7, 32'h77);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd8;
    @(negedge clock);
    n_vec += 2;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sb_issue_ok: got %b want 1", issue_ready); end
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_pre_busy: got %b want 0", rs1_busy); end
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clock);
    n_vec += 3;
    if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_rs1_busy: got %b want 1", rs1_busy); end
    if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL sb_rs2_free: got %b want 0", rs2_busy); end
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sb_waw_stall: got %b want 0", issue_ready); end
    next_cycle();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    @(negedge clock);
    n_vec++;
    if (ld_ready !== 1'b1) begin n_err++; $display("FAIL sb_ld_ready: got %b want 1", ld_ready); end
    push_exp(5'd9, 32'h99);
    next_cycle();
    idle();
    @(negedge clock);
    n_vec++;
    if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_n1: got %b want 1", rs1_busy); end
    next_cycle();
    @(negedge clock);
    n_vec += 2;
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_busy_n2: got %b want 0", rs1_busy); end
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sb_reissue: got %b want 1", issue_ready); end
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clock);
    n_vec++;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sb_issue_x0: got %b want 1", issue_ready); end
    next_cycle();
    idle();
    rs1 = 5'd0;
    @(negedge clock);
    n_vec++;
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_x0_busy: got %b want 0", rs1_busy); end
    next_cycle();
  endtask

  task automatic test_same_edge();
    rs1 = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hA9;
    @(negedge clock);
    n_vec++;
    if (ld_ready !== 1'b1) begin n_err++; $display("FAIL se_ld_ready: got %b want 1", ld_ready); end
    push_exp(5'd9, 32'hA9);
    next_cycle();
    ld_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clock);
    n_vec++;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL se_issue_ready: got %b want 1", issue_ready); end
    next_cycle();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hB9;
    @(negedge clock);
    n_vec += 2;
    if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL se_set_wins: got %b want 1", rs1_busy); end
    if (alu_ready !== 1'b1) begin n_err++; $display("FAIL se_alu_ready: got %b want 1", alu_ready); end
    push_exp(5'd9, 32'hB9);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clock);
    n_vec++;
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL se_cleared: got %b want 0", rs1_busy); end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    issue_valid = 1'b1; issue_rd = 5'd13;
    @(negedge clock);
    n_vec++;
    if (alu_ready !== 1'b1) begin n_err++; $display("FAIL mf_alu_ready: got %b want 1", alu_ready); end
    push_exp(5'd12, 32'hC);
    next_cycle();
    reset = 1'b1;
    alu_rd = 5'd14; alu_data = 32'hE;
    ld_valid = 1'b1; ld_rd = 5'd15; ld_data = 32'hF;
    issue_rd = 5'd20;
    @(negedge clock);
    n_vec += 3;
    if (alu_ready !== 1'b0) begin n_err++; $display("FAIL mf_alu_rst: got %b want 0", alu_ready); end
    if (ld_ready !== 1'b0) begin n_err++; $display("FAIL mf_ld_rst: got %b want 0", ld_ready); end
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL mf_issue_rst: got %b want 0", issue_ready); end
    next_cycle();
    reset = 1'b0;
    idle();
    rs1 = 5'd13; rs2 = 5'd20;
    @(negedge clock);
    n_vec += 4;
    if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL mf_busy13: got %b want 0", rs1_busy); end
    if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL mf_busy20: got %b want 0", rs2_busy); end
    if (writeRegId !== 5'd0) begin n_err++; $display("FAIL mf_regid: got %0d want 0", writeRegId); end
    if (writeData !== 32'h0) begin n_err++; $display("FAIL mf_data: got %h want 0", writeData); end
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_x0_bypass();
    test_contention();
    test_fixed_prio();
    test_scoreboard();
    test_same_edge();
    test_reset_midflight();
    mon_en = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_writes: got %0d outstanding want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
